// File: rtl/wisc_pipe_pkg.sv
// Shared types and constants for the WISC pipeline control logic.
package wisc_pipe_pkg;

  // Hazard controller FSM states.
  typedef enum logic [1:0] {
    RUN,
    DMEM_WAIT,
    DRAIN,
    HALTED
  } hc_state_t;

  // R0 is hard-wired to zero, so it can never carry a data dependence.
  localparam logic [3:0] REG_ZERO = 4'h0;

  // Encoding loaded into IF_ID on a flush (ADD R0,R0,R0; result discarded).
  localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: flags when the ID instruction reads the
// destination of a load currently in EX. Also used by the forwarding unit.
module load_use_detect (
  input  logic       mem_read,
  input  logic [3:0] ex_rd,
  input  logic [3:0] id_rs,
  input  logic [3:0] id_rt,
  input  logic       uses_rs,
  input  logic       uses_rt,
  output logic       lu
);
  import wisc_pipe_pkg::*;

  logic rs_hit;
  logic rt_hit;

  // Only operands actually read by the ID instruction can create a hazard.
  always_comb begin
    rs_hit = uses_rs && (ex_rd == id_rs);
    rt_hit = uses_rt && (ex_rd == id_rt);
    lu     = mem_read && (ex_rd != REG_ZERO) && (rs_hit || rt_hit);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline control unit: load-use stalls, branch squash, memory-stall freeze,
// and HLT drain/stop. Outputs are combinational from state and inputs.
module hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       ID_Rs,
  input  logic [3:0]       ID_Rt,
  input  logic             ID_uses_Rs,
  input  logic             ID_uses_Rt,
  input  logic             ID_halt,
  input  logic             ID_branch_taken,
  input  logic             EX_MemRead,
  input  logic [3:0]       EX_Rd,
  input  logic             imem_stall,
  input  logic             dmem_stall,
  output logic             PC_wen,
  output logic             IF_ID_wen,
  output logic             IF_ID_flush,
  output logic             ID_EX_wen,
  output logic             ID_EX_bubble,
  output logic             EX_MEM_wen,
  output logic             MEM_WB_wen,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);
  import wisc_pipe_pkg::*;

  // The halt cycle itself is the first of the DRAIN_CYCLES, so the counter
  // only tracks the remaining DRAIN-state cycles.
  localparam int unsigned DrainW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

  hc_state_t         state_q, state_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic              lu;
  logic              cnt_inc;

  load_use_detect u_lu (
    .mem_read (EX_MemRead),
    .ex_rd    (EX_Rd),
    .id_rs    (ID_Rs),
    .id_rt    (ID_Rt),
    .uses_rs  (ID_uses_Rs),
    .uses_rt  (ID_uses_Rt),
    .lu       (lu)
  );

  // Next-state and pipeline-register control, priority dmem > lu > imem > branch > halt.
  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    PC_wen       = 1'b1;
    IF_ID_wen    = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_wen    = 1'b1;
    ID_EX_bubble = 1'b0;
    EX_MEM_wen   = 1'b1;
    MEM_WB_wen   = 1'b1;
    halted       = 1'b0;
    if (!rst) begin
      if (state_q == HALTED) begin
        PC_wen     = 1'b0;
        IF_ID_wen  = 1'b0;
        ID_EX_wen  = 1'b0;
        EX_MEM_wen = 1'b0;
        MEM_WB_wen = 1'b0;
        halted     = 1'b1;
      end else if (dmem_stall) begin
        PC_wen     = 1'b0;
        IF_ID_wen  = 1'b0;
        ID_EX_wen  = 1'b0;
        EX_MEM_wen = 1'b0;
        MEM_WB_wen = 1'b0;
        // DRAIN keeps its state and counter frozen.
        if (state_q != DRAIN) state_d = DMEM_WAIT;
      end else if (state_q == DRAIN) begin
        PC_wen      = 1'b0;
        IF_ID_flush = 1'b1;
        drain_d     = drain_q - DrainW'(1);
        if (drain_q <= DrainW'(1)) state_d = HALTED;
      end else begin
        // RUN, or DMEM_WAIT on its first stall-free cycle.
        state_d = RUN;
        if (lu) begin
          PC_wen       = 1'b0;
          IF_ID_wen    = 1'b0;
          ID_EX_bubble = 1'b1;
        end else if (imem_stall) begin
          PC_wen      = 1'b0;
          IF_ID_flush = 1'b1;
        end else if (ID_branch_taken) begin
          IF_ID_flush = 1'b1;
        end else if (ID_halt) begin
          PC_wen      = 1'b0;
          IF_ID_flush = 1'b1;
          state_d     = DRAIN;
          drain_d     = DrainW'(DRAIN_CYCLES - 1);
        end
      end
    end
  end

  // Stall cycles count only while the program is still running.
  always_comb begin
    cnt_inc = !rst && !PC_wen && ((state_q == RUN) || (state_q == DMEM_WAIT));
  end

  // State, drain counter and saturating stall counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      drain_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      if (cnt_inc && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
